// File: rtl/bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// bcd_add_sequencer
//
// Multi-digit BCD adder that reuses one single-digit add/decimal-correct stage
// across DIGITS operand digits, least significant digit first, one digit per
// clock. A start/busy/done handshake frames each operation.
//
// Optional build macro: BCD_SUBTRACT_EN
//   When defined, a sub_i port is added. sub_i=1 replaces every B digit by its
//   nines' complement and forces the initial carry to 1, so the result is the
//   ten's-complement difference A-B (cout_o=1 means no borrow).
//
// Ports:
//   Clock    in   system clock, rising edge
//   Resetn   in   asynchronous active-low reset
//   start_i  in   request a new operation, honoured only when idle
//   a_i      in   operand A, packed BCD, digit 0 in [3:0]
//   b_i      in   operand B, packed BCD
//   cin_i    in   carry into digit 0
//   sub_i    in   (BCD_SUBTRACT_EN only) 1 = compute A-B
//   sum_o    out  packed BCD result, held until the next accepted start
//   cout_o   out  carry out of the most significant digit, held with sum_o
//   busy_o   out  high while adding and during the done cycle
//   done_o   out  one-cycle pulse when sum_o/cout_o/err_o are valid
//   err_o    out  some operand digit was above 9 in the last operation
// ---------------------------------------------------------------------------
module bcd_add_sequencer #(
  parameter int DIGITS = 3
) (
  input  logic                  Clock,
  input  logic                  Resetn,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   a_i,
  input  logic [4*DIGITS-1:0]   b_i,
  input  logic                  cin_i,
`ifdef BCD_SUBTRACT_EN
  input  logic                  sub_i,
`endif
  output logic [4*DIGITS-1:0]   sum_o,
  output logic                  cout_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;

`ifdef BCD_SUBTRACT_EN
  logic             sub_q, sub_d;
`else
  logic             sub_q;
  assign sub_q = 1'b0;
`endif

  // Digit currently being processed.
  logic [3:0] a_dig, b_dig, b_eff, digit;
  logic [4:0] s5;
  logic       gt9;

  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_dig = a_q[i*4 +: 4];
        b_dig = b_q[i*4 +: 4];
      end
    end
  end

  // Nines' complement wraps modulo 16 so invalid B digits still produce a
  // deterministic (if meaningless) result; err_o flags them on the raw value.
  assign b_eff = sub_q ? (4'd9 - b_dig) : b_dig;
  assign s5    = {1'b0, a_dig} + {1'b0, b_eff} + {4'd0, carry_q};
  assign gt9   = (s5 > 5'd9);
  // Adding 6 in 4 bits equals taking the low nibble of (s5 + 6).
  assign digit = gt9 ? (s5[3:0] + 4'd6) : s5[3:0];

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
`ifdef BCD_SUBTRACT_EN
    sub_d   = sub_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          a_d     = a_i;
          b_d     = b_i;
          idx_d   = '0;
          err_d   = 1'b0;
          sum_d   = '0;
`ifdef BCD_SUBTRACT_EN
          sub_d   = sub_i;
          carry_d = sub_i ? 1'b1 : cin_i;
`else
          carry_d = cin_i;
`endif
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*4 +: 4] = digit;
          end
        end
        carry_d = gt9;
        err_d   = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
        if (idx_q == LAST_IDX) begin
          // Carry-out is registered together with the final digit so that it
          // is already valid in the done cycle.
          cout_d  = gt9;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef BCD_SUBTRACT_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
`ifdef BCD_SUBTRACT_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign err_o  = err_q;
  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// ---------------------------------------------------------------------------
// tb_bcd_add_sequencer
//
// Directed and randomized checks of bcd_add_sequencer (DIGITS=3). Expected
// results come from decimal integer arithmetic when all digits are valid, and
// from the per-digit add/correct rule when some digit exceeds 9.
// ---------------------------------------------------------------------------
module tb_bcd_add_sequencer;

  localparam int DIGITS = 3;
  localparam int W      = 4 * DIGITS;

  logic         Clock = 1'b0;
  logic         Resetn;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic [W-1:0] sum;
  logic         cout, busy, done, err;

  int compared;
  int mismatched;

  always #5 Clock = ~Clock;

  bcd_add_sequencer #(.DIGITS(DIGITS)) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .cin_i   (cin),
`ifdef BCD_SUBTRACT_EN
    .sub_i   (sub),
`endif
    .sum_o   (sum),
    .cout_o  (cout),
    .busy_o  (busy),
    .done_o  (done),
    .err_o   (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int pow10d();
    int p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    return p;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] v = '0;
    int m = n;
    for (int i = 0; i < DIGITS; i++) begin
      v[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return v;
  endfunction

  function automatic bit all_valid(input logic [W-1:0] v);
    bit ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic ci, input logic sb,
                       output logic [W-1:0] es, output logic ec, output logic ee);
    int total, c, ad, bd, t;
    ee = !(all_valid(av) && all_valid(bv));
    if (!ee) begin
      if (sb) total = bcd2int(av) + (pow10d() - 1 - bcd2int(bv)) + 1;
      else    total = bcd2int(av) + bcd2int(bv) + int'(ci);
      es = int2bcd(total % pow10d());
      ec = (total >= pow10d());
    end else begin
      c  = sb ? 1 : int'(ci);
      es = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ad = int'(av[i*4 +: 4]);
        bd = int'(bv[i*4 +: 4]);
        if (sb) bd = (9 - bd) & 15;
        t = ad + bd + c;
        if (t > 9) begin es[i*4 +: 4] = 4'((t + 6) & 15); c = 1; end
        else       begin es[i*4 +: 4] = 4'(t);            c = 0; end
      end
      ec = c[0];
    end
  endtask

  // One complete operation with cycle-accurate handshake checks. With
  // disturb set, operands change after capture and start is re-pulsed while
  // busy; neither may affect the result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input bit disturb,
                        input string tag);
    logic [W-1:0] es;
    logic ec, ee;
`ifdef BCD_SUBTRACT_EN
    model(av, bv, ci, sb, es, ec, ee);
`else
    model(av, bv, ci, 1'b0, es, ec, ee);
`endif
    @(negedge Clock);
    a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    check({tag, ".busy1"}, 32'(busy), 32'd1);
    check({tag, ".done1"}, 32'(done), 32'd0);
    if (disturb) begin
      a = ~av; b = $urandom_range(0, 4095); cin = ~ci; sub = ~sb;
    end
    for (int c = 2; c <= DIGITS; c++) begin
      @(posedge Clock); #1;
      check({tag, ".busy_add"}, 32'(busy), 32'd1);
      check({tag, ".done_add"}, 32'(done), 32'd0);
      if (disturb && c == 2) start = 1'b1;
    end
    @(posedge Clock); #1;
    start = 1'b0;
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".busy_done"}, 32'(busy), 32'd1);
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".err"}, 32'(err), 32'(ee));
    @(posedge Clock); #1;
    check({tag, ".done_off"}, 32'(done), 32'd0);
    check({tag, ".busy_off"}, 32'(busy), 32'd0);
    check({tag, ".sum_hold"}, 32'(sum), 32'(es));
    check({tag, ".cout_hold"}, 32'(cout), 32'(ec));
    $display("op %-10s a=%03h b=%03h cin=%0b sub=%0b -> sum=%03h cout=%0b err=%0b (exp %03h %0b %0b)",
             tag, av, bv, ci, sb, sum, cout, err, es, ec, ee);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra, rb;
    logic         rs;
    compared   = 0;
    mismatched = 0;
    Resetn = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    repeat (2) @(posedge Clock);
    #1;
    check("rst.sum",  32'(sum),  32'd0);
    check("rst.cout", 32'(cout), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.err",  32'(err),  32'd0);
    @(negedge Clock);
    Resetn = 1'b1;

    run_op(12'h123, 12'h456, 1'b0, 1'b0, 1'b0, "add579");
    run_op(12'h999, 12'h001, 1'b0, 1'b0, 1'b0, "carry_all");
    run_op(12'h058, 12'h047, 1'b1, 1'b0, 1'b0, "cin1");
    run_op(12'h314, 12'h271, 1'b0, 1'b0, 1'b1, "disturb");

    // Continuous start: one operation every DIGITS+2 cycles.
    @(negedge Clock);
    a = 12'h250; b = 12'h250; cin = 1'b0; sub = 1'b0; start = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(posedge Clock); #1;
      check("cont.done", 32'(done), 32'((n % 5) == 3));
      check("cont.busy", 32'(busy), 32'((n % 5) != 4));
      if ((n % 5) == 3) check("cont.sum", 32'(sum), 32'h500);
      if (n == 14) start = 1'b0;
    end
    $display("op continuous a=250 b=250 -> three back-to-back results");

    run_op(12'h1A0, 12'h000, 1'b0, 1'b0, 1'b0, "err_digit");

    // Reset in the middle of an operation.
    @(negedge Clock);
    a = 12'hA12; b = 12'h345; cin = 1'b0; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
    @(posedge Clock); #1;
    Resetn = 1'b0;
    #1;
    check("midrst.sum",  32'(sum),  32'd0);
    check("midrst.cout", 32'(cout), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.err",  32'(err),  32'd0);
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    for (int n = 0; n < DIGITS + 2; n++) begin
      @(posedge Clock); #1;
      check("midrst.nodone", 32'(done), 32'd0);
      check("midrst.idle",   32'(busy), 32'd0);
    end
    $display("op midreset  aborted, outputs cleared");

    run_op(12'h808, 12'h191, 1'b1, 1'b0, 1'b0, "after_rst");

`ifdef BCD_SUBTRACT_EN
    run_op(12'h500, 12'h123, 1'b0, 1'b1, 1'b0, "sub_pos");
    run_op(12'h123, 12'h500, 1'b1, 1'b1, 1'b0, "sub_neg");
    run_op(12'h123, 12'h456, 1'b0, 1'b0, 1'b0, "sub_off");
`endif

    // Randomized operations with valid digits, occasionally disturbed.
    for (int t = 0; t < 20; t++) begin
      ra = '0; rb = '0;
      for (int i = 0; i < DIGITS; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
`ifdef BCD_SUBTRACT_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      run_op(ra, rb, 1'($urandom_range(0, 1)), rs, bit'($urandom_range(0, 3) == 0), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bcd_add_sequencer.md
Name: bcd_add_sequencer

Overview:
Multi-digit BCD adder controller that time-shares a single one-digit BCD add/correct stage across DIGITS operand digits, least significant digit first, one digit per clock.
Sits between the switch/key input logic and the binary-to-BCD/seven-segment display path. Replaces a wide combinational ripple adder with a start/busy/done sequenced datapath.

Parameters:
DIGITS, 3, number of BCD digits per operand and result (1..8)

Ports:
Clock  input  1  system clock, all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
start  input  1  request new operation; sampled only in IDLE
a  input  4*DIGITS  operand A, packed BCD, digit 0 in [3:0]
b  input  4*DIGITS  operand B, packed BCD
cin  input  1  carry-in to digit 0
sum  output  4*DIGITS  packed BCD result, held until next accepted start
cout  output  1  carry out of most significant digit, held with sum
busy  output  1  high from the cycle after start is accepted through the DONE cycle
done  output  1  one-cycle pulse when sum/cout become valid
err  output  1  one or more operand digits > 9 in the last operation; held with sum

Behaviour:
- One clock (Clock); reset is asynchronous and active-low (Resetn). Resetn=0 immediately forces state=IDLE, sum=0, cout=0, busy=0, done=0, err=0, digit index=0, carry=0.
- FSM states: IDLE, ADD, DONE.
- IDLE: if start=1 at an edge, capture a, b, cin into internal registers. Set carry=cin, idx=0, err=0, sum=0. Go to ADD. Otherwise stay in IDLE.
- ADD, one digit per cycle at index idx:
  - s5 = A[idx] + B[idx] + carry, 5-bit.
  - If s5 > 9: digit = (s5+6)[3:0], carry=1. Else digit = s5[3:0], carry=0.
  - Write digit to sum[idx].
  - If A[idx] > 9 or B[idx] > 9, set err=1 (sticky for this operation). The computation proceeds with the same rule.
  - Increment idx. After idx reaches DIGITS-1, go to DONE.
- DONE: cout=carry, done=1 for exactly this cycle. Go to IDLE.
- Latency:
  - start sampled at edge k.
  - ADD occupies cycles k+1..k+DIGITS.
  - done=1 in cycle k+DIGITS+1.
  - The next start is accepted no earlier than edge k+DIGITS+2.
- busy=1 in ADD and DONE states, 0 in IDLE.
- start while busy=1 is ignored, not queued.
- Operand changes after capture have no effect on the operation in progress.
- sum digits update progressively during ADD. They are guaranteed valid only from the done cycle onward.
- sum, cout and err hold until the next accepted start.
- Reset mid-operation aborts the operation. No done pulse is produced; all outputs go to reset values.
- DIGITS=1: a single ADD cycle, then DONE.

Optional Feature:
BCD_SUBTRACT_EN:
- Defined: adds input port sub (1 bit), captured with the operands at start.
  - sub=1: B digits are replaced by nines' complement (9 - B[idx]) mod 16, and carry-in is forced to 1 (cin ignored). The result is the ten's-complement difference A-B.
  - cout=1 means no borrow (A >= B); cout=0 means the result is the ten's complement of B-A.
  - err is still computed on the raw B digits.
  - sub=0 behaves exactly as the base block.
- Undefined: no sub port; addition only.

Test Plan (DIGITS=3):
- Reset, then start with a=0x123, b=0x456, cin=0 → busy high for 4 cycles; done pulses once at cycle k+4; sum=0x579, cout=0, err=0.
- a=0x999, b=0x001, cin=0 → sum=0x000, cout=1; a=0x058, b=0x047, cin=1 → sum=0x106, cout=0.
- Pulse start again 2 cycles into an operation with different operands → ignored; the first result is delivered unchanged. start held high continuously → done pulses every 5 cycles.
- a=0x1A0, b=0x000 → err=1 at done; a following valid operation clears err=0.
- Assert Resetn=0 for one cycle during ADD → sum=0, cout=0, busy=0, no done pulse; a subsequent start completes normally.
- With BCD_SUBTRACT_EN: sub=1, a=0x500, b=0x123 → sum=0x377, cout=1; a=0x123, b=0x500 → sum=0x623, cout=0.
